key_conditioner: RTL and testbench



---
 rtl/key_conditioner_if.sv | 21 ++
 rtl/key_conditioner.sv | 135 +++++++++++++
 tb/tb_key_conditioner.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw key levels in, debounced levels and strobes out.
// Master drives the buttons, slave is the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] pulse;

  modport master (
    output key_n,
    input  level,
    input  pulse
  );

  modport slave (
    input  key_n,
    output level,
    output pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: per-key sync, debounce, press strobe and auto-repeat.
// Feeds set_min / set_hr / set_TMOD of the clock core.
module key_conditioner #(
  parameter int                N_KEYS           = 3,
  parameter int                DEBOUNCE_CYC     = 1_000_000,
  parameter int                REPEAT_DELAY_CYC = 25_000_000,
  parameter int                REPEAT_RATE_CYC  = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK      = 3'b011
) (
  input logic               clk,
  input logic               rst,
  key_conditioner_if.slave  kif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam int RP_MAX =
    (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RP_W = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RD_LAST =
    RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RR_LAST =
    RP_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  logic [N_KEYS-1:0] lvl_vec;
  logic [N_KEYS-1:0] pls_vec;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [1:0]      sync_q;
    logic            synced;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_nxt;
    logic            lvl_q;
    logic            lvl_nxt;
    state_t          state_q;
    state_t          state_nxt;
    logic [RP_W-1:0] rp_cnt;
    logic [RP_W-1:0] rp_nxt;
    logic            pls_q;
    logic            pls_nxt;

    assign synced = ~sync_q[1];

    always_comb begin
      lvl_nxt = lvl_q;
      db_nxt  = '0;
      if (synced != lvl_q) begin
        if (db_cnt == DB_LAST) begin
          lvl_nxt = synced;
        end else begin
          db_nxt = db_cnt + 1'b1;
        end
      end
    end

    // FSM looks at next level so the press strobe lines up with level
    always_comb begin
      state_nxt = state_q;
      rp_nxt    = rp_cnt;
      pls_nxt   = 1'b0;
      unique case (state_q)
        IDLE: begin
          rp_nxt = '0;
          if (lvl_nxt && !lvl_q) begin
            pls_nxt = 1'b1;
            if (REPEAT_MASK[k]) begin
              state_nxt = DELAY;
            end
          end
        end
        DELAY: begin
          if (!lvl_nxt) begin
            state_nxt = IDLE;
            rp_nxt    = '0;
          end else if (rp_cnt == RD_LAST) begin
            pls_nxt   = 1'b1;
            rp_nxt    = '0;
            state_nxt = REPEAT;
          end else begin
            rp_nxt = rp_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!lvl_nxt) begin
            state_nxt = IDLE;
            rp_nxt    = '0;
          end else if (rp_cnt == RR_LAST) begin
            pls_nxt = 1'b1;
            rp_nxt  = '0;
          end else begin
            rp_nxt = rp_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rp_nxt    = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= 2'b11;
        db_cnt  <= '0;
        lvl_q   <= 1'b0;
        state_q <= IDLE;
        rp_cnt  <= '0;
        pls_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], kif.key_n[k]};
        db_cnt  <= db_nxt;
        lvl_q   <= lvl_nxt;
        state_q <= state_nxt;
        rp_cnt  <= rp_nxt;
        pls_q   <= pls_nxt;
      end
    end

    assign lvl_vec[k] = lvl_q;
    assign pls_vec[k] = pls_q;
  end

  assign kif.level = lvl_vec;
  assign kif.pulse = pls_vec;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for the key conditioner.
// Expected strobes are planned at press time and matched per cycle.
module tb_key_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = 2 + DB;
  localparam logic [2:0] REP_MASK = 3'b011;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  key_conditioner_if #(.N_KEYS(3)) kif ();

  key_conditioner #(
    .N_KEYS           (3),
    .DEBOUNCE_CYC     (DB),
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_RATE_CYC  (RR),
    .REPEAT_MASK      (REP_MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Press at c0, release at r: strobes from press until level falls
  task automatic sb_plan(input logic [2:0] m,
                         input int c0,
                         input int r);
    int p;
    int f;
    logic [2:0] v;
    exp_t e;
    p = c0 + LAT;
    f = r + LAT;
    for (int t = p; t < f; t++) begin
      v = '0;
      for (int k = 0; k < 3; k++) begin
        if (m[k]) begin
          if (t == p)
            v[k] = 1'b1;
          else if (REP_MASK[k] && t >= p + RD &&
                   (t - p - RD) % RR == 0)
            v[k] = 1'b1;
        end
      end
      if (v != '0) begin
        e.cyc = t;
        e.val = v;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("pulse_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (kif.pulse != '0) begin
        if (sb.size() == 0) begin
          check("pulse_unexp", int'(kif.pulse), 0);
        end else begin
          check("pulse_cyc", cyc, sb[0].cyc);
          check("pulse_val", int'(kif.pulse),
                int'(sb[0].val));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int c0;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    kif.key_n = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_level", int'(kif.level), 0);
    check("rst_pulse", int'(kif.pulse), 0);
    rst = 1'b0;
    wait_to(cyc + 5);

    // clean press on key 0, held 8
    c0 = cyc;
    kif.key_n[0] = 1'b0;
    sb_plan(3'b001, c0, c0 + 8);
    wait_to(c0 + LAT - 1);
    check("s1_lvl_pre", int'(kif.level[0]), 0);
    wait_to(c0 + LAT);
    check("s1_lvl_up", int'(kif.level[0]), 1);
    wait_to(c0 + 8);
    kif.key_n[0] = 1'b1;
    wait_to(c0 + 8 + LAT - 1);
    check("s1_lvl_hold", int'(kif.level[0]), 1);
    wait_to(c0 + 8 + LAT);
    check("s1_lvl_down", int'(kif.level[0]), 0);
    wait_to(cyc + 10);

    // bounce on key 1 then stable low
    for (int i = 0; i < 5; i++) begin
      kif.key_n[1] = 1'b0;
      wait_to(cyc + 2);
      kif.key_n[1] = 1'b1;
      wait_to(cyc + 2);
    end
    check("s2_lvl_bounce", int'(kif.level[1]), 0);
    c0 = cyc;
    kif.key_n[1] = 1'b0;
    sb_plan(3'b010, c0, c0 + 8);
    wait_to(c0 + 8);
    kif.key_n[1] = 1'b1;
    wait_to(cyc + 12);

    // auto-repeat on key 0, held 24
    c0 = cyc;
    kif.key_n[0] = 1'b0;
    sb_plan(3'b001, c0, c0 + 24);
    wait_to(c0 + 24);
    kif.key_n[0] = 1'b1;
    wait_to(c0 + 24 + LAT);
    check("s3_lvl_down", int'(kif.level[0]), 0);
    wait_to(cyc + 5);
    c0 = cyc;
    kif.key_n[0] = 1'b0;
    sb_plan(3'b001, c0, c0 + 5);
    wait_to(c0 + 5);
    kif.key_n[0] = 1'b1;
    wait_to(cyc + 15);

    // masked key 2, held 40
    c0 = cyc;
    kif.key_n[2] = 1'b0;
    sb_plan(3'b100, c0, c0 + 40);
    wait_to(c0 + 39);
    check("s4_lvl_held", int'(kif.level[2]), 1);
    wait_to(c0 + 40);
    kif.key_n[2] = 1'b1;
    wait_to(c0 + 40 + LAT - 1);
    check("s4_lvl_hold", int'(kif.level[2]), 1);
    wait_to(c0 + 40 + LAT);
    check("s4_lvl_down", int'(kif.level[2]), 0);
    wait_to(cyc + 10);

    // reset while repeating on key 0
    c0 = cyc;
    kif.key_n[0] = 1'b0;
    sb_plan(3'b001, c0, c0 + 16);
    wait_to(c0 + LAT + RD + 2 * RR - 1);
    @(posedge clk);
    #1;
    check("s5_pulse_pre", int'(kif.pulse[0]), 1);
    rst = 1'b1;
    #1;
    check("s5_pulse_rst", int'(kif.pulse), 0);
    check("s5_lvl_rst", int'(kif.level), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    sb_plan(3'b001, c0, c0 + 18);
    wait_to(c0 + LAT - 1);
    check("s5_lvl_pre", int'(kif.level[0]), 0);
    wait_to(c0 + LAT);
    check("s5_lvl_up", int'(kif.level[0]), 1);
    wait_to(c0 + 18);
    kif.key_n[0] = 1'b1;
    wait_to(cyc + 12);

    // simultaneous press on keys 0 and 1
    c0 = cyc;
    kif.key_n[1:0] = 2'b00;
    sb_plan(3'b011, c0, c0 + 26);
    wait_to(c0 + 26);
    kif.key_n[1:0] = 2'b11;
    wait_to(c0 + 26 + LAT);
    check("s6_lvl_down", int'(kif.level), 0);
    wait_to(cyc + 10);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
